// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI frame receiver.
//   FRAME_BITS : length of a valid SPI frame (rw + addr + data)
//   ADDR_W     : address field width
//   DATA_W     : data field width
//   state_e    : receiver FSM states (IDLE, SHIFT)
//   cnt_inc_sat: bit-counter increment that saturates at CNT_SAT
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  // Saturating one past a full frame keeps overlong frames distinguishable
  // from exact-length ones without letting the counter wrap back to 16.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_SAT) ? CNT_SAT : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver_if
// Bundles the raw SPI pins and the decoded frame outputs.
//   sclk, copi, ncs          : raw SPI pins (driven by master)
//   valid                    : one-cycle pulse per accepted frame
//   read_write, addr, data   : decoded frame fields
//   frame_err                : sticky bad-length flag (SPI_ERR_FLAG_EN only)
// Modports: master = SPI side / consumer, slave = the receiver.
// Optional feature macro: SPI_ERR_FLAG_EN
// -----------------------------------------------------------------------------
interface spi_frame_receiver_if;
  import spi_pkg::*;

  logic              sclk;
  logic              copi;
  logic              ncs;
  logic              valid;
  logic              read_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

`ifdef SPI_ERR_FLAG_EN
  logic              frame_err;

  modport master (output sclk, copi, ncs,
                  input  valid, read_write, addr, data, frame_err);
  modport slave  (input  sclk, copi, ncs,
                  output valid, read_write, addr, data, frame_err);
`else
  modport master (output sclk, copi, ncs,
                  input  valid, read_write, addr, data);
  modport slave  (input  sclk, copi, ncs,
                  output valid, read_write, addr, data);
`endif

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for an asynchronous input.
//   clk     : destination clock
//   rst     : asynchronous active-high reset
//   d_i     : asynchronous input
//   q_o     : synchronized output
// Parameter RST_VAL sets the level both flops take during reset, so the
// output idles at the pin's inactive level.
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
// SPI mode-0 slave receiver for 16-bit frames {rw, addr[6:0], data[7:0]},
// MSB first, oversampled by the system clock.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : spi_frame_receiver_if.slave (raw sclk/copi/ncs in; valid,
//          read_write, addr, data and optional frame_err out)
// A frame is accepted only if exactly 16 sclk rising edges occur while ncs
// is low; the decoded fields then update together with a one-cycle valid.
// Optional feature macro: SPI_ERR_FLAG_EN (adds sticky frame_err).
// -----------------------------------------------------------------------------
module spi_frame_receiver
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  spi_frame_receiver_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic sclk_s, copi_s, ncs_s;
  logic sclk_q, ncs_q;
  logic [1:0] settle_q;
  logic armed_q;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(bus.sclk), .q_o(sclk_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d_i(bus.copi), .q_o(copi_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d_i(bus.ncs),  .q_o(ncs_s));

  // The synchronizers come out of reset at the idle level, so a chip select
  // already low at release would look like a fresh falling edge. Frame
  // starts are only armed once the pipeline has flushed and ncs has been
  // seen high, which drops any frame that began during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      ncs_q  <= ncs_s;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end else if (ncs_s && ncs_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = armed_q & ncs_q & ~ncs_s;
  assign ncs_rise  = ncs_s & ~ncs_q;

  // ---------------------------------------------------------------------------
  // Shift datapath next state
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sclk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      cnt_d   = cnt_inc_sat(cnt_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic               valid_q;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
`ifdef SPI_ERR_FLAG_EN
  logic               err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef SPI_ERR_FLAG_EN
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // sclk activity is ignored here; only a chip-select start matters.
          if (ncs_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
          // Length is judged on the _d values so a final sclk edge that
          // coincides with the ncs rise is counted first.
          if (ncs_rise) begin
            state_q <= IDLE;
            if (cnt_d == CNT_FULL) begin
              valid_q <= 1'b1;
              rw_q    <= shift_d[FRAME_BITS-1];
              addr_q  <= shift_d[FRAME_BITS-2 -: ADDR_W];
              data_q  <= shift_d[DATA_W-1:0];
            end
`ifdef SPI_ERR_FLAG_EN
            else begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid      = valid_q;
  assign bus.read_write = rw_q;
  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
`ifdef SPI_ERR_FLAG_EN
  assign bus.frame_err  = err_q;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
// Directed bench for spi_frame_receiver. Drives mode-0 SPI frames through the
// interface, collects every valid pulse at the falling clock edge and checks
// decoded fields, pulse counts, latency and held outputs against
// hand-computed values. frame_err is checked only with SPI_ERR_FLAG_EN.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_frame_receiver_if bus ();

  spi_frame_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt  = 0;
  int mis_cnt  = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int last_lat = 0;
  logic [15:0] seen_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Each cycle valid is high pushes one entry, so a stretched pulse shows up
  // as an extra frame.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      seen_q.push_back({bus.read_write, bus.addr, bus.data});
      last_lat = cyc - rise_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bit(input logic b);
    bus.copi = b;
    tick(4);
    bus.sclk = 1'b1;
    tick(4);
    bus.sclk = 1'b0;
  endtask

  task automatic start_frame();
    bus.ncs = 1'b0;
    tick(4);
  endtask

  task automatic end_frame(input int gap);
    tick(4);
    bus.ncs  = 1'b1;
    rise_cyc = cyc;
    tick(gap);
  endtask

  task automatic send_frame(input logic [15:0] f, input int gap);
    start_frame();
    for (int i = 15; i >= 0; i--) spi_bit(f[i]);
    end_frame(gap);
  endtask

  task automatic send_bits(input int n, input logic [31:0] pat, input int gap);
    start_frame();
    for (int i = n - 1; i >= 0; i--) spi_bit(pat[i]);
    end_frame(gap);
  endtask

  task automatic expect_count(input string tag, input int n);
    check({tag, "_pulses"}, seen_q.size(), n);
  endtask

  task automatic pop_frame(input string tag, input logic rw, input logic [6:0] addr,
                           input logic [7:0] data);
    logic [15:0] w;
    if (seen_q.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      w = seen_q.pop_front();
      check({tag, "_rw"},   w[15],   rw);
      check({tag, "_addr"}, w[14:8], addr);
      check({tag, "_data"}, w[7:0],  data);
    end
  endtask

  task automatic check_outputs(input string tag, input logic rw, input logic [6:0] addr,
                               input logic [7:0] data);
    check({tag, "_rw"},   bus.read_write, rw);
    check({tag, "_addr"}, bus.addr,       addr);
    check({tag, "_data"}, bus.data,       data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    tick(3);

    // Reset state
    check("rst_valid", bus.valid, 0);
    check_outputs("rst", 1'b0, 7'h00, 8'h00);
`ifdef SPI_ERR_FLAG_EN
    check("rst_err", bus.frame_err, 0);
`endif
    rst = 1'b0;
    tick(8);

    // sclk toggling while deselected: nothing happens
    for (int i = 0; i < 10; i++) begin
      bus.copi = i[0];
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
      tick(4);
    end
    expect_count("idle", 0);
    check_outputs("idle", 1'b0, 7'h00, 8'h00);

    // Write frame 0x80F0
    send_frame(16'h80F0, 8);
    expect_count("f80f0", 1);
    pop_frame("f80f0", 1'b1, 7'h00, 8'hF0);
    check("f80f0_latency_le4", (last_lat <= 4), 1);
    check("f80f0_valid_low", bus.valid, 0);
`ifdef SPI_ERR_FLAG_EN
    check("f80f0_err", bus.frame_err, 0);
`endif

    // Back-to-back with minimum chip-select gap
    send_frame(16'h04AA, 3);
    send_frame(16'h8155, 8);
    expect_count("b2b", 2);
    pop_frame("b2b_first", 1'b0, 7'h04, 8'hAA);
    pop_frame("b2b_second", 1'b1, 7'h01, 8'h55);

    // Short frame (12 bits): discarded, outputs held
    send_bits(12, 32'h0000_0ABC, 8);
    expect_count("short", 0);
    check_outputs("short_hold", 1'b1, 7'h01, 8'h55);
`ifdef SPI_ERR_FLAG_EN
    check("short_err", bus.frame_err, 1);
`endif

    // Overlong frame (20 bits): discarded, outputs held
    send_bits(20, 32'h000F_0F0F, 8);
    expect_count("long", 0);
    check_outputs("long_hold", 1'b1, 7'h01, 8'h55);
`ifdef SPI_ERR_FLAG_EN
    check("long_err", bus.frame_err, 1);
`endif

    // Last sclk rise coincident with ncs rise: bit counted, frame accepted
    start_frame();
    for (int i = 15; i >= 1; i--) spi_bit(16'h3C5A >> i);
    bus.copi = 1'b0;
    tick(4);
    bus.sclk = 1'b1;
    bus.ncs  = 1'b1;
    rise_cyc = cyc;
    tick(4);
    bus.sclk = 1'b0;
    tick(8);
    expect_count("coinc", 1);
    pop_frame("coinc", 1'b0, 7'h3C, 8'h5A);
    check("coinc_latency_le4", (last_lat <= 4), 1);

    // Reset after bit 8 of a frame
    start_frame();
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", bus.valid, 0);
    check_outputs("midrst", 1'b0, 7'h00, 8'h00);
`ifdef SPI_ERR_FLAG_EN
    check("midrst_err", bus.frame_err, 0);
`endif
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(1'b0);
    end_frame(8);
    expect_count("midrst_after", 0);
    check_outputs("midrst_after", 1'b0, 7'h00, 8'h00);

    // Full frame after the abandoned one
    send_frame(16'h8204, 8);
    expect_count("f8204", 1);
    pop_frame("f8204", 1'b1, 7'h02, 8'h04);
    check_outputs("f8204_hold", 1'b1, 7'h02, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
